// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-subsystem definitions: arbiter state encoding and the default
// bus geometry used by the memory, the arbiter and their benches.
package mem_pkg;

  localparam int MEM_WIDTH = 32;
  localparam int MEM_ADDR  = 8;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o
);

  always_comb begin
    gnt_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_o = ~last_i;
    end else begin
      gnt_o = req_i[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter letting two masters share one valid/ready memory port,
// with a latched request per transaction and a timeout abort.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int WIDTH   = MEM_WIDTH,
  parameter int DEPTH   = MEM_DEPTH,
  parameter int ADDR    = MEM_ADDR,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  input  logic             r0_wrbar,
  input  logic [ADDR-1:0]  r0_addr,
  input  logic [WIDTH-1:0] r0_wdata,
  output logic             r0_ready,
  output logic             r0_err,
  output logic [WIDTH-1:0] r0_rdata,
  input  logic             r1_valid,
  input  logic             r1_wrbar,
  input  logic [ADDR-1:0]  r1_addr,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             r1_ready,
  output logic             r1_err,
  output logic [WIDTH-1:0] r1_rdata,
  output logic             mem_valid,
  output logic             mem_wrbar,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             owner,
  output logic             busy
);

  // A zero TIMEOUT still needs a 1-bit counter to keep the logic well formed.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  if (DEPTH != (1 << ADDR)) begin : g_depth_check
    $error("mem_port_arbiter: DEPTH must equal 2**ADDR");
  end

  arb_state_e       state_q;
  logic             owner_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mem_wrbar_q;
  logic [ADDR-1:0]  mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic             pick;
  logic             done;
  logic             abort;

  rr_arb2 u_rr_arb2 (
    .req_i  ({r1_valid, r0_valid}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      mem_wrbar_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (r0_valid || r1_valid) begin
            state_q     <= BUSY;
            owner_q     <= pick;
            last_q      <= pick;
            cnt_q       <= '0;
            mem_wrbar_q <= pick ? r1_wrbar : r0_wrbar;
            mem_addr_q  <= pick ? r1_addr  : r0_addr;
            mem_wdata_q <= pick ? r1_wdata : r0_wdata;
          end
        end
        BUSY: begin
          // A ready arriving on the final allowed cycle still wins over abort.
          if (mem_ready) begin
            state_q <= IDLE;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
            state_q <= ABORT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ABORT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done  = (state_q == BUSY) && mem_ready;
  assign abort = (state_q == ABORT);

  assign mem_valid = (state_q == BUSY);
  assign mem_wrbar = mem_wrbar_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);

  // Only the owner ever sees completion; aborted reads return zero data.
  assign r0_ready = (done || abort) && !owner_q;
  assign r0_err   = abort && !owner_q;
  assign r0_rdata = (done && !owner_q) ? mem_rdata : '0;
  assign r1_ready = (done || abort) && owner_q;
  assign r1_err   = abort && owner_q;
  assign r1_rdata = (done && owner_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for single transactions,
// hand sequences for contention, timeout and asynchronous reset.
module tb_mem_port_arbiter;

  localparam int W  = 32;
  localparam int A  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0_valid, r0_wrbar, r1_valid, r1_wrbar;
  logic [A-1:0] r0_addr, r1_addr;
  logic [W-1:0] r0_wdata, r1_wdata;
  logic         r0_ready, r0_err, r1_ready, r1_err;
  logic [W-1:0] r0_rdata, r1_rdata;
  logic         mem_valid, mem_wrbar, mem_ready;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata, mem_rdata;
  logic         owner, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .DEPTH(256), .ADDR(A), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_wrbar(r0_wrbar), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_wrbar(r1_wrbar), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_valid(mem_valid), .mem_wrbar(mem_wrbar), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  typedef struct {
    logic r0v; logic r0w; logic [A-1:0] r0a; logic [W-1:0] r0d;
    logic r1v; logic r1w; logic [A-1:0] r1a; logic [W-1:0] r1d;
    logic mrdy; logic [W-1:0] mrd;
    logic e_mv; logic e_mw; logic [A-1:0] e_ma; logic [W-1:0] e_md;
    logic e_own; logic e_busy;
    logic e_r0rdy; logic e_r0err; logic e_r1rdy; logic e_r1err;
    logic [W-1:0] e_r0rd; logic [W-1:0] e_r1rd;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    r0_valid = 0; r0_wrbar = 0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_wrbar = 0; r1_addr = '0; r1_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // r0 write, r1 read-back, address stability, IDLE ignores mem_ready
    vecs[0]  = '{0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,32'h0,          0,0,8'h00,32'h0,        0,0, 0,0,0,0, 32'h0,32'h0};
    vecs[1]  = '{1,1,8'h05,32'hDEADBEEF, 0,0,8'h00,32'h0, 0,32'h0,   0,0,8'h00,32'h0,        0,0, 0,0,0,0, 32'h0,32'h0};
    vecs[2]  = '{0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,32'h0,          1,1,8'h05,32'hDEADBEEF, 0,1, 0,0,0,0, 32'h0,32'h0};
    vecs[3]  = '{0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 1,32'h0,          1,1,8'h05,32'hDEADBEEF, 0,1, 1,0,0,0, 32'h0,32'h0};
    vecs[4]  = '{0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,32'h0,          0,1,8'h05,32'hDEADBEEF, 0,0, 0,0,0,0, 32'h0,32'h0};
    vecs[5]  = '{0,0,8'h00,32'h0, 1,0,8'h05,32'h0, 0,32'h0,          0,1,8'h05,32'hDEADBEEF, 0,0, 0,0,0,0, 32'h0,32'h0};
    vecs[6]  = '{0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,32'h0,          1,0,8'h05,32'h0,        1,1, 0,0,0,0, 32'h0,32'h0};
    vecs[7]  = '{0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 1,32'hDEADBEEF,   1,0,8'h05,32'h0,        1,1, 0,0,1,0, 32'h0,32'hDEADBEEF};
    vecs[8]  = '{0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,32'h0,          0,0,8'h05,32'h0,        1,0, 0,0,0,0, 32'h0,32'h0};
    vecs[9]  = '{1,0,8'h10,32'h11111111, 0,0,8'h00,32'h0, 0,32'h0,   0,0,8'h05,32'h0,        1,0, 0,0,0,0, 32'h0,32'h0};
    vecs[10] = '{1,0,8'h20,32'h22222222, 0,0,8'h00,32'h0, 0,32'h0,   1,0,8'h10,32'h11111111, 0,1, 0,0,0,0, 32'h0,32'h0};
    vecs[11] = '{1,0,8'h20,32'h22222222, 0,0,8'h00,32'h0, 1,32'h12345678, 1,0,8'h10,32'h11111111, 0,1, 1,0,0,0, 32'h12345678,32'h0};
    vecs[12] = '{1,0,8'h20,32'h22222222, 0,0,8'h00,32'h0, 0,32'h0,   0,0,8'h10,32'h11111111, 0,0, 0,0,0,0, 32'h0,32'h0};
    vecs[13] = '{0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,32'h0,          1,0,8'h20,32'h22222222, 0,1, 0,0,0,0, 32'h0,32'h0};
    vecs[14] = '{0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 1,32'hA5A5A5A5,   1,0,8'h20,32'h22222222, 0,1, 1,0,0,0, 32'hA5A5A5A5,32'h0};
    vecs[15] = '{0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 1,32'h5A5A5A5A,   0,0,8'h20,32'h22222222, 0,0, 0,0,0,0, 32'h0,32'h0};

    // Reset state, sampled while rst is still asserted
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst mem_valid", W'(mem_valid), 0);
    chk("rst busy", W'(busy), 0);
    chk("rst owner", W'(owner), 0);
    chk("rst mem_addr", W'(mem_addr), 0);
    chk("rst r0_ready", W'(r0_ready), 0);
    chk("rst r1_ready", W'(r1_ready), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r0_valid = vecs[i].r0v; r0_wrbar = vecs[i].r0w; r0_addr = vecs[i].r0a; r0_wdata = vecs[i].r0d;
      r1_valid = vecs[i].r1v; r1_wrbar = vecs[i].r1w; r1_addr = vecs[i].r1a; r1_wdata = vecs[i].r1d;
      mem_ready = vecs[i].mrdy; mem_rdata = vecs[i].mrd;
      #1;
      chk($sformatf("v%0d mem_valid", i), W'(mem_valid), W'(vecs[i].e_mv));
      chk($sformatf("v%0d mem_wrbar", i), W'(mem_wrbar), W'(vecs[i].e_mw));
      chk($sformatf("v%0d mem_addr", i),  W'(mem_addr),  W'(vecs[i].e_ma));
      chk($sformatf("v%0d mem_wdata", i), mem_wdata,     vecs[i].e_md);
      chk($sformatf("v%0d owner", i),     W'(owner),     W'(vecs[i].e_own));
      chk($sformatf("v%0d busy", i),      W'(busy),      W'(vecs[i].e_busy));
      chk($sformatf("v%0d r0_ready", i),  W'(r0_ready),  W'(vecs[i].e_r0rdy));
      chk($sformatf("v%0d r0_err", i),    W'(r0_err),    W'(vecs[i].e_r0err));
      chk($sformatf("v%0d r1_ready", i),  W'(r1_ready),  W'(vecs[i].e_r1rdy));
      chk($sformatf("v%0d r1_err", i),    W'(r1_err),    W'(vecs[i].e_r1err));
      chk($sformatf("v%0d r0_rdata", i),  r0_rdata,      vecs[i].e_r0rd);
      chk($sformatf("v%0d r1_rdata", i),  r1_rdata,      vecs[i].e_r1rd);
    end

    // Contention from reset: both hold valid, grants alternate r0,r1,r0,r1
    do_reset();
    r0_valid = 1; r0_addr = 8'h01;
    r1_valid = 1; r1_addr = 8'h02;
    @(posedge clk);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      #1;
      chk($sformatf("cont%0d busy", t), W'(busy), 1);
      chk($sformatf("cont%0d owner", t), W'(owner), W'(t % 2));
      chk($sformatf("cont%0d mem_addr", t), W'(mem_addr), (t % 2 == 0) ? 32'h01 : 32'h02);
      mem_ready = 1; mem_rdata = 32'h100 + t;
      #1;
      chk($sformatf("cont%0d r0_ready", t), W'(r0_ready), W'(t % 2 == 0));
      chk($sformatf("cont%0d r1_ready", t), W'(r1_ready), W'(t % 2 == 1));
      @(negedge clk);
      mem_ready = 0;
      #1;
      chk($sformatf("cont%0d idle", t), W'(busy), 0);
      @(posedge clk);
    end

    // Timeout: memory never answers an r1 read
    do_reset();
    r1_valid = 1; r1_wrbar = 0; r1_addr = 8'h33;
    @(posedge clk);
    @(negedge clk);
    r1_valid = 0;
    for (int c = 0; c < TO; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("to c%0d mem_valid", c), W'(mem_valid), 1);
      chk($sformatf("to c%0d r1_ready", c), W'(r1_ready), 0);
    end
    @(negedge clk);
    mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
    #1;
    chk("abort mem_valid", W'(mem_valid), 0);
    chk("abort busy", W'(busy), 1);
    chk("abort r1_ready", W'(r1_ready), 1);
    chk("abort r1_err", W'(r1_err), 1);
    chk("abort r1_rdata", r1_rdata, 0);
    chk("abort r0_ready", W'(r0_ready), 0);
    @(negedge clk);
    mem_ready = 0;
    #1;
    chk("post-abort busy", W'(busy), 0);
    chk("post-abort r1_ready", W'(r1_ready), 0);

    // Ready on the last allowed cycle completes normally
    r1_valid = 1;
    @(posedge clk);
    @(negedge clk);
    r1_valid = 0;
    for (int c = 0; c < TO - 1; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("late c%0d mem_valid", c), W'(mem_valid), 1);
    end
    @(negedge clk);
    mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("late mem_valid", W'(mem_valid), 1);
    chk("late r1_ready", W'(r1_ready), 1);
    chk("late r1_err", W'(r1_err), 0);
    chk("late r1_rdata", r1_rdata, 32'hCAFEF00D);
    @(negedge clk);
    mem_ready = 0;
    #1;
    chk("late after busy", W'(busy), 0);
    chk("late after r1_ready", W'(r1_ready), 0);

    // Asynchronous reset in the middle of an r0 write
    r0_valid = 1; r0_wrbar = 1; r0_addr = 8'h44; r0_wdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    r0_valid = 0;
    #1;
    chk("amr busy before", W'(busy), 1);
    chk("amr owner before", W'(owner), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("amr mem_valid", W'(mem_valid), 0);
    chk("amr busy", W'(busy), 0);
    chk("amr r0_ready", W'(r0_ready), 0);
    chk("amr r0_err", W'(r0_err), 0);
    @(negedge clk);
    rst = 1'b0;
    r0_valid = 1; r0_addr = 8'h0A;
    r1_valid = 1; r1_addr = 8'h0B;
    #1;
    chk("amr idle r0_ready", W'(r0_ready), 0);
    @(negedge clk);
    #1;
    chk("amr regrant busy", W'(busy), 1);
    chk("amr regrant owner", W'(owner), 0);
    chk("amr regrant mem_addr", W'(mem_addr), 32'h0A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter sharing one single-port memory that uses the valid/ready handshake (addr, wdata, wrbar, valid in; rdata, ready out).
- Sits between two masters (e.g. a DMA-style filler and a reader) and the memory.
- Latches the granted request and holds it stable until memory ready.
- Aborts a transaction with an error pulse if ready does not arrive within TIMEOUT cycles.

Parameters:
- WIDTH, 32, data width of memory and requester data buses
- DEPTH, 256, memory depth (documentation only; must equal 2**ADDR)
- ADDR, 8, address width
- TIMEOUT, 16, max BUSY cycles before abort; 0 disables the timeout

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- r0_valid  in  1  requester 0 request
- r0_wrbar  in  1  requester 0: 1 = write, 0 = read
- r0_addr  in  ADDR  requester 0 address
- r0_wdata  in  WIDTH  requester 0 write data
- r0_ready  out  1  requester 0 transaction done (1-cycle pulse)
- r0_err  out  1  requester 0 timeout abort (pulses together with r0_ready)
- r0_rdata  out  WIDTH  requester 0 read data, valid when r0_ready=1 and read
- r1_valid, r1_wrbar, r1_addr, r1_wdata, r1_ready, r1_err, r1_rdata: same as r0_*
- mem_valid  out  1  request to memory
- mem_wrbar  out  1  memory write(1)/read(0)
- mem_addr  out  ADDR  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_ready  in  1  memory completion
- mem_rdata  in  WIDTH  memory read data, valid with mem_ready on reads
- owner  out  1  index of current/last granted requester
- busy  out  1  state != IDLE

Behaviour:

Reset:
- All outputs 0; state IDLE; timeout count 0.
- Round-robin pointer last=1, so r0 wins the first tie.
- Reset is asynchronous: asserting rst mid-transaction drops mem_valid immediately; no ready or err is issued for the aborted request.

State machine:
- IDLE:
  - If any rk_valid=1, grant at the clock edge and go to BUSY.
  - Grant rule: the sole requester; if both request, the one != last.
  - On grant, register that requester's addr/wdata/wrbar into mem_*, set owner=k, last=k, count=0.
- BUSY:
  - mem_valid=1; mem_* come from registers only, so requester inputs may change freely.
  - If mem_ready=1: rk_ready=1 for the owner this cycle (combinational), rk_rdata=mem_rdata; next state IDLE.
  - Else if TIMEOUT!=0 and count==TIMEOUT-1: next state ABORT.
  - Else count+1.
- ABORT (1 cycle):
  - mem_valid=0; owner's rk_ready=1 and rk_err=1; rk_rdata=0.
  - mem_ready in this state is ignored.
  - Next state IDLE.

Handshake and timing:
- A request is consumed at the edge where rk_ready=1. A requester still asserting rk_valid in the next cycle is making a new request.
- Grant latency: one edge. Request seen in IDLE at cycle N gives mem_valid=1 from cycle N+1.
- Minimum per-transaction occupancy: 2 cycles (IDLE + BUSY). Back-to-back requests always pass through IDLE.
- mem_ready arriving in the same cycle that count hits TIMEOUT-1 completes normally, with no err.
- mem_valid stays high for at most TIMEOUT cycles.
- Non-owner rk_ready, rk_err and rk_rdata are 0 at all times.
- A requester's rk_valid dropping during BUSY has no effect; the latched transaction completes.

Widths:
- Timeout count is $clog2(TIMEOUT+1) bits and saturates at TIMEOUT-1 (no wrap).
- The arbiter has no address arithmetic; it does not range-check addresses.

Decomposition:
- Shared package mem_pkg holds:
  - state enum IDLE/BUSY/ABORT
  - default WIDTH/ADDR/DEPTH constants, shared with the memory and its benches
- One sub-module: rr_arb2, a combinational 2-way round-robin pick from (req[1:0], last) to grant index.
- FSM, request latch and timeout counter stay in the top.

Test Plan:
- Single write: r0 writes addr 0x05 data 0xDEADBEEF. Expect mem_valid in the cycle after r0_valid, mem_addr=0x05, mem_wrbar=1. When mem_ready pulses, r0_ready=1 the same cycle, then busy=0.
- Read back: r1 reads 0x05. Expect r1_rdata=0xDEADBEEF with r1_ready; r0_ready stays 0.
- Contention: r0 and r1 both hold valid for 4 transactions from reset. Grant order r0,r1,r0,r1; owner toggles each transaction.
- Stability: r0 changes r0_addr from 0x10 to 0x20 mid-BUSY. mem_addr stays 0x10 until mem_ready.
- Timeout: with TIMEOUT=16, the memory never asserts ready for an r1 read. mem_valid is high for exactly 16 cycles, then 1 ABORT cycle with r1_ready=1 and r1_err=1, then IDLE. Repeat with mem_ready on the 16th cycle: normal completion, r1_err=0.
- Reset mid-BUSY: assert rst between edges during a write. mem_valid and busy go 0 immediately, no ready is pulsed, and the first grant after reset goes to r0 when both request.
